// File: rtl/face_coord_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : face_coord_collector
// Purpose  : Buffers Viola-Jones detections, maps them to base-image boxes and
//            streams each box plus a per-frame terminator/count to a UART.
// Revision : 1.0 - initial release
// ============================================================================
module face_coord_collector #(
  parameter int FIFO_DEPTH  = 16,
  parameter int LEVELS      = 10,
  parameter int WINDOW_SIZE = 24,
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   det_valid,
  input  logic [3:0]             det_level,
  input  logic [31:0]            det_row,
  input  logic [31:0]            det_col,
  input  logic                   scan_done,
  input  logic [LEVELS*32-1:0]   level_scale,
  output logic [3:0][31:0]       face_coords,
  output logic                   face_coords_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   busy
);

  localparam int          c_AW    = $clog2(FIFO_DEPTH);
  localparam int          c_PW    = c_AW + 1;
  localparam logic [31:0] c_ONE   = 32'h0001_0000;
  localparam logic [31:0] c_XMAX  = 32'(IMG_WIDTH - 1);
  localparam logic [31:0] c_YMAX  = 32'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL_X = 3'd1,
    ST_MUL_Y = 3'd2,
    ST_MUL_S = 3'd3,
    ST_EMIT  = 3'd4,
    ST_SEND  = 3'd5,
    ST_TERM  = 3'd6
  } state_t;

  state_t r_state, w_next;

  logic [21:0]          r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]      r_wr_ptr, r_rd_ptr, w_count;
  logic                 w_empty, w_full, w_clear, w_pop, w_push;
  logic                 w_xfer, w_send_last, w_term_last;

  logic [3:0]           r_lvl;
  logic [8:0]           r_row, r_col;
  logic [31:0]          r_x0, r_y0;
  logic [3:0][31:0]     r_face_coords;
  logic                 r_face_ready, r_frame_done, r_overflow, r_done_seen;
  logic [7:0]           r_face_cnt;
  logic [2:0]           r_idx;

  logic [31:0]          w_scale_tab [16];
  logic [31:0]          w_scale, w_mul_a, w_res, w_s;
  logic [63:0]          w_prod;
  logic                 w_prod_unused;
  logic [32:0]          w_x1_sum, w_y1_sum;
  logic [31:0]          w_x0c, w_y0c, w_x1, w_y1;
  logic [15:0]          w_field;

  // ---------------------------------------------------------------- FIFO
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == c_PW'(FIFO_DEPTH));
  assign w_clear     = frame_start && (r_state == ST_IDLE);
  assign w_pop       = (r_state == ST_IDLE) && !w_clear && !w_empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign w_push      = det_valid && !w_clear && (!w_full || w_pop);
  assign w_xfer      = tx_valid && tx_ready;
  assign w_send_last = (r_state == ST_SEND) && w_xfer && (r_idx == 3'd7);
  assign w_term_last = (r_state == ST_TERM) && w_xfer && (r_idx == 3'd2);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {det_level, det_row[8:0], det_col[8:0]};
    end
  end

  // ----------------------------------------------------- scale lookup
  for (genvar gi = 0; gi < 16; gi++) begin : g_scale
    if (gi < LEVELS) begin : g_lvl
      assign w_scale_tab[gi] = level_scale[gi*32 +: 32];
    end else begin : g_def
      assign w_scale_tab[gi] = c_ONE;
    end
  end

  assign w_scale = w_scale_tab[r_lvl];

  // Single shared multiplier; the operand is chosen by the current phase.
  always_comb begin
    w_mul_a = 32'(WINDOW_SIZE);
    case (r_state)
      ST_MUL_X: w_mul_a = {23'd0, r_col};
      ST_MUL_Y: w_mul_a = {23'd0, r_row};
      default:  w_mul_a = 32'(WINDOW_SIZE);
    endcase
  end

  assign w_prod        = {32'd0, w_mul_a} * {32'd0, w_scale};
  assign w_res         = w_prod[47:16];
  assign w_prod_unused = ^{w_prod[63:48], w_prod[15:0]};

  assign w_s      = (w_res == '0) ? 32'd1 : w_res;
  assign w_x1_sum = {1'b0, r_x0} + {1'b0, w_s} - 33'd1;
  assign w_y1_sum = {1'b0, r_y0} + {1'b0, w_s} - 33'd1;
  assign w_x1     = (w_x1_sum > {1'b0, c_XMAX}) ? c_XMAX : w_x1_sum[31:0];
  assign w_y1     = (w_y1_sum > {1'b0, c_YMAX}) ? c_YMAX : w_y1_sum[31:0];
  assign w_x0c    = (r_x0 > c_XMAX) ? c_XMAX : r_x0;
  assign w_y0c    = (r_y0 > c_YMAX) ? c_YMAX : r_y0;

  // ------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop)                        w_next = ST_MUL_X;
        else if (!w_clear && r_done_seen) w_next = ST_TERM;
      end
      ST_MUL_X: w_next = ST_MUL_Y;
      ST_MUL_Y: w_next = ST_MUL_S;
      ST_MUL_S: w_next = ST_EMIT;
      ST_EMIT:  w_next = ST_SEND;
      ST_SEND:  if (w_send_last) w_next = ST_IDLE;
      ST_TERM:  if (w_term_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Byte source: big-endian 16-bit fields while sending, FF FF count at frame end.
  assign w_field = r_face_coords[r_idx[2:1]][15:0];

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    case (r_state)
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = r_idx[0] ? w_field[7:0] : w_field[15:8];
      end
      ST_TERM: begin
        tx_valid = 1'b1;
        tx_data  = (r_idx == 3'd2) ? r_face_cnt : 8'hFF;
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  assign busy = (r_state != ST_IDLE);

  // -------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_lvl         <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_x0          <= '0;
      r_y0          <= '0;
      r_face_coords <= '0;
      r_face_ready  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
      r_done_seen   <= 1'b0;
      r_face_cnt    <= '0;
      r_idx         <= '0;
    end else begin
      r_face_ready <= 1'b0;
      r_frame_done <= w_term_last;

      if (w_clear) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_face_cnt  <= '0;
        r_overflow  <= 1'b0;
        r_done_seen <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_face_cnt != 8'hFF) r_face_cnt <= r_face_cnt + 8'd1;
        end
        if (det_valid && !w_push) r_overflow <= 1'b1;
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          {r_lvl, r_row, r_col} <= r_mem[r_rd_ptr[c_AW-1:0]];
        end
        if (w_term_last)    r_done_seen <= 1'b0;
        else if (scan_done) r_done_seen <= 1'b1;
      end

      if (r_state == ST_MUL_X) r_x0 <= w_res;
      if (r_state == ST_MUL_Y) r_y0 <= w_res;
      // Box becomes visible with the ready pulse during the EMIT cycle.
      if (r_state == ST_MUL_S) begin
        r_face_coords[0] <= w_x0c;
        r_face_coords[1] <= w_y0c;
        r_face_coords[2] <= w_x1;
        r_face_coords[3] <= w_y1;
        r_face_ready     <= 1'b1;
      end

      if (w_xfer) r_idx <= (w_send_last || w_term_last) ? 3'd0 : r_idx + 3'd1;
    end
  end

  assign face_coords       = r_face_coords;
  assign face_coords_ready = r_face_ready;
  assign frame_done        = r_frame_done;
  assign overflow          = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_face_coord_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_face_coord_collector
// Purpose  : Randomised and directed self-checking bench with a transaction
//            level model of boxes, byte stream and frame terminators.
// Revision : 1.0 - initial release
// ============================================================================
module tb_face_coord_collector;

  typedef logic [3:0][31:0] box_t;

  logic         clock = 1'b0;
  logic         reset, frame_start, det_valid, scan_done, tx_ready;
  logic [3:0]   det_level;
  logic [31:0]  det_row, det_col;
  logic [319:0] level_scale;
  box_t         face_coords;
  logic         face_coords_ready, tx_valid, frame_done, overflow, busy;
  logic [7:0]   tx_data;

  always #5 clock = ~clock;

  face_coord_collector dut (
    .clock             (clock),
    .reset             (reset),
    .frame_start       (frame_start),
    .det_valid         (det_valid),
    .det_level         (det_level),
    .det_row           (det_row),
    .det_col           (det_col),
    .scan_done         (scan_done),
    .level_scale       (level_scale),
    .face_coords       (face_coords),
    .face_coords_ready (face_coords_ready),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .frame_done        (frame_done),
    .overflow          (overflow),
    .busy              (busy)
  );

  int           checks = 0;
  int           errors = 0;
  byte unsigned exp_bytes[$];
  box_t         exp_boxes[$];
  int           done_expected = 0;
  logic [31:0]  scales [10];
  int           tx_mode = 3;
  int           phase = 0;
  bit           prev_stall = 0;
  logic [7:0]   prev_data = 8'h00;
  byte unsigned lit_bytes [8] = '{8'h00, 8'h14, 8'h00, 8'h0A, 8'h00, 8'h2B, 8'h00, 8'h21};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  function automatic box_t mk(input int x0, input int y0, input int x1, input int y1);
    return {32'(y1), 32'(x1), 32'(y0), 32'(x0)};
  endfunction

  // Box from the mapping rules: level coords times 16.16 scale, then clip.
  function automatic box_t model_box(input int unsigned lvl, input logic [31:0] row,
                                     input logic [31:0] col);
    longint unsigned sc, r, c, x0, y0, s, x1, y1;
    sc = (lvl < 10) ? longint'(scales[lvl]) : 64'h1_0000;
    r  = row & 32'h1FF;
    c  = col & 32'h1FF;
    x0 = ((c * sc) >> 16) & 64'hFFFF_FFFF;
    y0 = ((r * sc) >> 16) & 64'hFFFF_FFFF;
    s  = ((24 * sc) >> 16) & 64'hFFFF_FFFF;
    if (s == 0) s = 1;
    x1 = x0 + s - 1;
    y1 = y0 + s - 1;
    if (x1 > 319) x1 = 319;
    if (y1 > 239) y1 = 239;
    if (x0 > 319) x0 = 319;
    if (y0 > 239) y0 = 239;
    return {y1[31:0], x1[31:0], y0[31:0], x0[31:0]};
  endfunction

  task automatic enq_box(input box_t b);
    exp_boxes.push_back(b);
    for (int k = 0; k < 4; k++) begin
      exp_bytes.push_back(b[k][15:8]);
      exp_bytes.push_back(b[k][7:0]);
    end
  endtask

  task automatic enq_term(input int cnt);
    exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'(cnt));
    done_expected++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_scales();
    for (int i = 0; i < 10; i++) level_scale[i*32 +: 32] = scales[i];
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic pulse_scan_done();
    scan_done = 1'b1;
    step(1);
    scan_done = 1'b0;
  endtask

  task automatic push_det(input int lvl, input logic [31:0] row, input logic [31:0] col,
                          input bit use_model, input bit with_done);
    det_valid = 1'b1;
    det_level = 4'(lvl);
    det_row   = row;
    det_col   = col;
    scan_done = with_done;
    if (use_model) enq_box(model_box(lvl, row, col));
    step(1);
    det_valid = 1'b0;
    scan_done = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_bytes.size() != 0 || done_expected != 0) && t < 6000) begin
      step(1);
      t++;
    end
    chk(name, (t < 6000), 1'b1);
    chk({name, "_boxes"}, exp_boxes.size(), 0);
  endtask

  always @(posedge clock) begin
    #1;
    case (tx_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      2: begin
        tx_ready = (phase == 0);
        phase    = (phase + 1) % 3;
      end
      default: tx_ready = 1'b0;
    endcase
  end

  // Compare process: every output event is checked against the model queues.
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall) chk("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
      if (tx_valid && tx_ready) begin
        if (exp_bytes.size() == 0) note_fail("tx_extra", $sformatf("unexpected byte %0h", tx_data));
        else chk("tx_byte", tx_data, exp_bytes.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (face_coords_ready) begin
        if (exp_boxes.size() == 0) note_fail("box_extra", $sformatf("unexpected box %0h", face_coords));
        else chk("box", face_coords, exp_boxes.pop_front());
      end
      if (frame_done) begin
        chk("frame_done_order", {(exp_bytes.size() == 0), (done_expected > 0)}, 2'b11);
        if (done_expected > 0) done_expected--;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int n, lvl;
    bit last_done;
    logic [31:0] row, col;

    reset = 1'b1; frame_start = 1'b0; det_valid = 1'b0; scan_done = 1'b0;
    det_level = '0; det_row = '0; det_col = '0; level_scale = '0;
    for (int i = 0; i < 10; i++) scales[i] = 32'h0001_0000 + 32'(i) * 32'h2000;
    scales[3] = 32'h0001_8000;
    apply_scales();
    #2 reset = 1'b0;
    step(3);
    @(negedge clock);
    chk("rst_coords", face_coords, '0);
    chk("rst_ready", face_coords_ready, 1'b0);
    chk("rst_txdata", tx_data, 8'h00);
    chk("rst_txvalid", tx_valid, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    step(2);

    chk("model_single", model_box(0, 10, 20), mk(20, 10, 43, 33));
    chk("model_lvl3", model_box(3, 8, 40), mk(60, 12, 95, 47));
    chk("model_clip", model_box(0, 230, 310), mk(310, 230, 319, 239));

    // Single detection with literal bytes
    tx_mode = 0;
    pulse_frame_start();
    exp_boxes.push_back(mk(20, 10, 43, 33));
    foreach (lit_bytes[k]) exp_bytes.push_back(lit_bytes[k]);
    push_det(0, 10, 20, 1'b0, 1'b0);
    pulse_scan_done();
    enq_term(1);
    wait_drain("single");

    // Scaled level and clipping
    pulse_frame_start();
    exp_boxes.push_back(mk(60, 12, 95, 47));
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'd60);
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'd12);
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'd95);
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'd47);
    push_det(3, 8, 40, 1'b0, 1'b0);
    enq_box(mk(310, 230, 319, 239));
    push_det(0, 230, 310, 1'b0, 1'b1);
    enq_term(2);
    wait_drain("scaled_clip");

    // Empty frame
    pulse_frame_start();
    pulse_scan_done();
    enq_term(0);
    wait_drain("empty");
    chk("empty_ovf", overflow, 1'b0);

    // Overflow: one pop then 16 buffered; the last three are dropped
    tx_mode = 3;
    step(1);
    pulse_frame_start();
    for (int i = 0; i < 20; i++)
      push_det(0, $urandom_range(0, 200), $urandom_range(0, 280), (i < 17), 1'b0);
    step(1);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_busy", busy, 1'b1);
    pulse_scan_done();
    enq_term(17);
    tx_mode = 0;
    wait_drain("overflow");
    chk("ovf_sticky", overflow, 1'b1);
    pulse_frame_start();
    chk("ovf_cleared", overflow, 1'b0);

    // Backpressure 1-of-3
    tx_mode = 2;
    push_det(5, 100, 150, 1'b1, 1'b1);
    enq_term(1);
    wait_drain("backpressure");

    // frame_start while busy is ignored
    tx_mode = 3;
    step(1);
    pulse_frame_start();
    for (int i = 0; i < 3; i++) push_det(i, 20 * i, 30 * i, 1'b1, 1'b0);
    step(10);
    chk("busy_before_fs", busy, 1'b1);
    pulse_frame_start();
    pulse_scan_done();
    enq_term(3);
    tx_mode = 2;
    wait_drain("fs_ignored");

    // Reset in the middle of SEND
    tx_mode = 3;
    step(1);
    pulse_frame_start();
    push_det(0, 50, 60, 1'b1, 1'b0);
    step(8);
    chk("mid_send_valid", tx_valid, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_txvalid", tx_valid, 1'b0);
    chk("rst_mid_txdata", tx_data, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_coords", face_coords, '0);
    chk("rst_mid_ovf_done", {overflow, frame_done, face_coords_ready}, 3'b000);
    exp_bytes.delete();
    exp_boxes.delete();
    done_expected = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    step(2);

    // Randomised frames, at most FIFO_DEPTH detections so none are dropped
    for (int f = 0; f < 12; f++) begin
      for (int i = 1; i < 10; i++)
        scales[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(32'h4000, 32'h40000));
      apply_scales();
      tx_mode = $urandom_range(0, 2);
      pulse_frame_start();
      n = $urandom_range(0, 16);
      last_done = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        step($urandom_range(0, 4));
        lvl = $urandom_range(0, 15);
        row = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 300));
        col = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 400));
        push_det(lvl, row, col, 1'b1, (i == n - 1) && last_done);
      end
      if (n == 0 || !last_done) pulse_scan_done();
      enq_term(n);
      wait_drain($sformatf("rand_frame%0d", f));
      chk("rand_ovf", overflow, 1'b0);
    end

    chk("final_queues", {32'(exp_bytes.size()), 32'(exp_boxes.size()), 32'(done_expected)}, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/face_coord_collector.md
Name: face_coord_collector

Overview:
- Sits directly downstream of the Viola-Jones pipeline/scan FSM and consumes each accepted window (pyramid level, row, col).
- Buffers detections in a FIFO and maps each one from pyramid-level coordinates back to base-image coordinates using per-level 16.16 scale factors.
- Presents each mapped box on face_coords/face_coords_ready and streams it as bytes to the UART transmitter.
- Closes every frame with a terminator and a face count.

Parameters:
- FIFO_DEPTH, 16, raw detection FIFO entries (power of 2)
- LEVELS, 10, number of pyramid levels
- WINDOW_SIZE, 24, scan window side in pixels
- IMG_WIDTH, 320, base image width
- IMG_HEIGHT, 240, base image height

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- frame_start  input  1  one-cycle pulse: new frame; clears frame state
- det_valid  input  1  detection present this cycle (no backpressure)
- det_level  input  4  pyramid level of detection
- det_row  input  32  window top row in level coordinates
- det_col  input  32  window left col in level coordinates
- scan_done  input  1  one-cycle pulse: last detection of frame issued
- level_scale  input  LEVELS*32  per-level scale, unsigned 16.16 (level 0 = 1.0)
- face_coords  output  4x32  {[0]=x0,[1]=y0,[2]=x1,[3]=y1} base-image box, inclusive
- face_coords_ready  output  1  one-cycle pulse: face_coords valid
- tx_data  output  8  byte to UART TX
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART TX accepts byte
- frame_done  output  1  one-cycle pulse after frame's count byte accepted
- overflow  output  1  sticky: a detection was dropped this frame
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, FIFO empty, face count 0, state IDLE, done_seen 0.
- FIFO push: det_valid pushes {level[3:0], row[8:0], col[8:0]}; high bits of row/col are discarded.
  - Push when full: entry dropped, overflow set.
  - Simultaneous pop and push when full: push accepted.
  - Accepted entry is visible to the pop side on the next cycle.
- face_cnt: 8-bit, saturates at 255, increments per accepted push.
- scan_done: sets done_seen. If det_valid arrives in the same cycle, that detection belongs to the current frame.
- frame_start: honoured only in IDLE; clears FIFO, face_cnt, overflow, done_seen. Otherwise it is ignored with no other effect.
- Datapath uses one shared 32x32->64 unsigned multiplier; results are bits [47:16] of the product (truncate).
- FSM:
  - IDLE: if FIFO non-empty, pop into working regs and go to MUL_X. Else if done_seen, go to TERM.
  - MUL_X: x0 = col*scale[level].
  - MUL_Y: y0 = row*scale[level].
  - MUL_S: s = WINDOW_SIZE*scale[level]. Then:
    - x1 = min(x0+s-1, IMG_WIDTH-1), y1 = min(y0+s-1, IMG_HEIGHT-1).
    - x0/y0 clip to IMG_WIDTH-1/IMG_HEIGHT-1.
    - If s==0, treat s as 1.
  - EMIT: register face_coords, pulse face_coords_ready for 1 cycle, go to SEND.
  - SEND: 8 bytes, big-endian 16-bit fields: x0, y0, x1, y1 (low 16 bits each). After the last byte, go to IDLE.
  - TERM: bytes 0xFF, 0xFF, face_cnt. After the last byte, pulse frame_done, clear done_seen, go to IDLE.
- Detection latency: pop-to-face_coords_ready is 4 cycles (MUL_X, MUL_Y, MUL_S, EMIT). face_coords holds until the next EMIT.
- TX handshake:
  - tx_valid rises with stable tx_data.
  - A byte transfers on a cycle where tx_valid & tx_ready.
  - tx_data/tx_valid must not change until transfer.
  - The next byte may be presented the cycle after transfer (back-to-back allowed).
  - tx_valid is low outside SEND/TERM.
- Level out of range (det_level >= LEVELS): use scale 1.0.
- Reset mid-operation: immediate return to reset state. A byte in flight is abandoned (tx_valid drops asynchronously).

Test Plan:
- Single detection: level 0, row 10, col 20, scale 0x0001_0000, tx_ready=1 -> face_coords {20,10,43,33} pulse 4 cycles after pop; bytes 00 14 00 0A 00 2B 00 21.
- Scaled level: level 3 scale 0x0001_8000, row 8, col 40 -> x0=60, y0=12, s=36, box {60,12,95,47}.
- Clipping: level 0 row 230 col 310 -> {310,230,319,239}.
- Overflow: 20 det_valid back-to-back with tx_ready=0 -> 16 buffered plus pops per FSM progress, overflow=1. After scan_done the count byte equals accepted pushes; the frame ends FF FF count, then a frame_done pulse.
- TX backpressure: tx_ready toggling 1-of-3 cycles -> tx_data stable while tx_valid & !tx_ready; all 8 bytes delivered in order, none duplicated.
- Empty frame and edge events:
  - frame_start then scan_done with no detections -> FF FF 00, frame_done.
  - frame_start while busy -> ignored.
  - reset low mid-SEND -> all outputs 0 immediately.
